vector_alu_scheduler: RTL and testbench

- Issue controller for the vector execute stage.
- Accepts decoded vector ops from decode over a valid/ready handshake and drives the vector ALU's op select and enable.
- Tracks in-flight results and emits an in-order writeback strobe carrying the destination tag.
- Serialises iterative ops (reductions, dot products) that occupy the ALU for multiple cycles against fully pipelined lane-wise ops, and keeps a per-register busy scoreboard so decode can detect RAW hazards.

---
 rtl/vector_sched_pkg.sv | 29 ++
 rtl/vector_wb_pipe.sv | 38 +++
 rtl/vector_alu_scheduler.sv | 160 ++++++++++++++++
 tb/tb_vector_alu_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_sched_pkg.sv
// Shared types and default latencies for the vector ALU issue scheduler.
package vector_sched_pkg;

    localparam int unsigned DEF_OP_W     = 5;
    localparam int unsigned DEF_TAG_W    = 5;
    localparam int unsigned DEF_PIPE_LAT = 2;
    localparam int unsigned DEF_ITER_LAT = 4;
    localparam int unsigned CNT_W        = 4;
    // Tag field width carried through the writeback pipe; the top's TAG_W must match.
    localparam int unsigned SB_TAG_W     = DEF_TAG_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PIPE  = 2'd1,
        DRAIN = 2'd2,
        ITER  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic                valid;
        logic [SB_TAG_W-1:0] dst;
        logic                scalar;
    } inflight_t;

    function automatic logic [CNT_W-1:0] iter_load(input int unsigned lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/vector_wb_pipe.sv
// Fixed-latency shift register tracking pipelined ops until writeback.
module vector_wb_pipe
    import vector_sched_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_PIPE_LAT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      stall,
    input  logic      flush,
    input  inflight_t push,
    output inflight_t tail,
    output logic      empty_c
);

    inflight_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
        end else if (!stall) begin
            stage[0] <= push;
            for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
        end
    end

    assign tail = stage[DEPTH-1];

    always_comb begin
        empty_c = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (stage[i].valid) empty_c = 1'b0;
        end
    end

endmodule

// File: rtl/vector_alu_scheduler.sv
// Issue controller for the vector execute stage: op issue, in-order
// writeback tracking, iterative-op serialisation and RAW scoreboards.
module vector_alu_scheduler
    import vector_sched_pkg::*;
#(
    parameter int unsigned OP_W     = DEF_OP_W,
    parameter int unsigned TAG_W    = DEF_TAG_W,
    parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
    parameter int unsigned ITER_LAT = DEF_ITER_LAT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     in_op,
    input  logic                in_iter,
    input  logic [TAG_W-1:0]    in_dst,
    input  logic                in_scalar,
    input  logic                wb_stall,
    input  logic                flush,
    output logic [OP_W-1:0]     alu_op,
    output logic                alu_en,
    output logic                alu_start,
    output logic                wb_valid,
    output logic [TAG_W-1:0]    wb_dst,
    output logic                wb_scalar,
    output logic [2**TAG_W-1:0] vbusy,
    output logic [2**TAG_W-1:0] sbusy
);

    localparam logic [CNT_W-1:0] ITER_LOAD = iter_load(ITER_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    sched_state_t       state, state_n;
    logic               accept;
    logic [CNT_W-1:0]   cnt;
    logic [TAG_W-1:0]   iter_dst;
    logic               iter_scalar;
    inflight_t          push;
    inflight_t          tail;
    logic               pipe_empty;
    logic [2**TAG_W-1:0] vbusy_n, sbusy_n;

    assign alu_en = rst_n & ~wb_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Issue gating and state transitions; an iterative op waits in DRAIN
    // until every pipelined result has left the shift register.
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        if (rst_n && !flush && !wb_stall)
            in_ready = (state == IDLE) || ((state == PIPE) && !in_iter);
        accept = in_valid && in_ready;
        if (flush) begin
            state_n = IDLE;
        end else if (!wb_stall) begin
            case (state)
                IDLE:  if (accept) state_n = in_iter ? ITER : PIPE;
                PIPE: begin
                    if (accept)                   state_n = PIPE;
                    else if (in_valid && in_iter) state_n = DRAIN;
                    else if (pipe_empty)          state_n = IDLE;
                end
                DRAIN: if (pipe_empty) state_n = IDLE;
                ITER:  if (cnt == '0)  state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        push.valid  = accept && !in_iter;
        push.dst    = SB_TAG_W'(in_dst);
        push.scalar = in_scalar;
    end

    vector_wb_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_wb_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (wb_stall),
        .flush   (flush),
        .push    (push),
        .tail    (tail),
        .empty_c (pipe_empty)
    );

    // Op select, iteration counter and the writeback register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            iter_dst    <= '0;
            iter_scalar <= 1'b0;
            alu_op      <= '0;
            alu_start   <= 1'b0;
            wb_valid    <= 1'b0;
            wb_dst      <= '0;
            wb_scalar   <= 1'b0;
        end else if (flush) begin
            cnt       <= '0;
            alu_start <= 1'b0;
            wb_valid  <= 1'b0;
        end else begin
            alu_start <= accept;
            if (!wb_stall) begin
                if (accept) alu_op <= in_op;
                if (accept && in_iter) begin
                    cnt         <= ITER_LOAD;
                    iter_dst    <= in_dst;
                    iter_scalar <= in_scalar;
                end else if (cnt != '0) begin
                    cnt <= cnt - CNT_ONE;
                end
                if ((state == ITER) && (cnt == CNT_ONE)) begin
                    wb_valid  <= 1'b1;
                    wb_dst    <= iter_dst;
                    wb_scalar <= iter_scalar;
                end else begin
                    wb_valid  <= tail.valid;
                    wb_dst    <= TAG_W'(tail.dst);
                    wb_scalar <= tail.scalar;
                end
            end
        end
    end

    // A retirement only completes on an unstalled cycle; a same-cycle set wins.
    always_comb begin
        vbusy_n = vbusy;
        sbusy_n = sbusy;
        if (wb_valid && !wb_stall) begin
            if (wb_scalar) sbusy_n[wb_dst] = 1'b0;
            else           vbusy_n[wb_dst] = 1'b0;
        end
        if (accept) begin
            if (in_scalar) sbusy_n[in_dst] = 1'b1;
            else           vbusy_n[in_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vbusy <= '0;
            sbusy <= '0;
        end else if (flush) begin
            vbusy <= '0;
            sbusy <= '0;
        end else begin
            vbusy <= vbusy_n;
            sbusy <= sbusy_n;
        end
    end

endmodule

// File: tb/tb_vector_alu_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of issue, retirement order and scoreboards.
module tb_vector_alu_scheduler;

    localparam int unsigned OP_W     = 5;
    localparam int unsigned TAG_W    = 5;
    localparam int unsigned PIPE_LAT = 2;
    localparam int unsigned ITER_LAT = 4;
    localparam int unsigned NREG     = 2**TAG_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_iter, in_scalar;
    logic [OP_W-1:0]  in_op;
    logic [TAG_W-1:0] in_dst;
    logic             wb_stall, flush;
    logic [OP_W-1:0]  alu_op;
    logic             alu_en, alu_start, wb_valid, wb_scalar;
    logic [TAG_W-1:0] wb_dst;
    logic [NREG-1:0]  vbusy, sbusy;

    always #5 clk = ~clk;

    vector_alu_scheduler #(
        .OP_W(OP_W), .TAG_W(TAG_W), .PIPE_LAT(PIPE_LAT), .ITER_LAT(ITER_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_iter(in_iter), .in_dst(in_dst), .in_scalar(in_scalar),
        .wb_stall(wb_stall), .flush(flush), .alu_op(alu_op), .alu_en(alu_en),
        .alu_start(alu_start), .wb_valid(wb_valid), .wb_dst(wb_dst),
        .wb_scalar(wb_scalar), .vbusy(vbusy), .sbusy(sbusy)
    );

    // Each in-flight op counts down the unstalled edges left before it is shown on wb.
    typedef struct {
        logic [TAG_W-1:0] dst;
        logic             sc;
        bit               iter;
        int               rem;
    } mop_t;

    mop_t            q[$];
    logic [NREG-1:0] m_vbusy, m_sbusy;
    logic [OP_W-1:0] m_op;
    logic            m_start;
    int              since;
    int              total = 0;
    int              bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_vbusy = '0;
        m_sbusy = '0;
        m_op    = '0;
        m_start = 1'b0;
        since   = 100;
    endtask

    task automatic check_outputs();
        bit exp_wb;
        exp_wb = (q.size() > 0) && (q[0].rem == 0);
        check("wb_valid", wb_valid, exp_wb);
        if (exp_wb) begin
            check("wb_dst", wb_dst, q[0].dst);
            check("wb_scalar", wb_scalar, q[0].sc);
        end
        check("vbusy", vbusy, m_vbusy);
        check("sbusy", sbusy, m_sbusy);
        check("alu_op", alu_op, m_op);
        check("alu_start", alu_start, m_start);
    endtask

    task automatic model_edge(input bit acc, input bit it, input logic [OP_W-1:0] op,
                              input logic [TAG_W-1:0] dst, input bit sc,
                              input bit st, input bit fl);
        bit   popped_pipe;
        mop_t m;
        if (fl) begin
            q.delete();
            m_vbusy = '0;
            m_sbusy = '0;
            m_start = 1'b0;
            since   = 100;
        end else if (st) begin
            m_start = 1'b0;
        end else begin
            popped_pipe = 1'b0;
            if (q.size() > 0 && q[0].rem == 0) begin
                if (q[0].sc) m_sbusy[q[0].dst] = 1'b0;
                else         m_vbusy[q[0].dst] = 1'b0;
                popped_pipe = !q[0].iter;
                void'(q.pop_front());
            end
            if (popped_pipe)      since = 0;
            else if (since < 100) since++;
            foreach (q[i]) if (q[i].rem > 0) q[i].rem = q[i].rem - 1;
            m_start = acc;
            if (acc) begin
                m.dst  = dst;
                m.sc   = sc;
                m.iter = it;
                m.rem  = it ? int'(ITER_LAT) - 1 : int'(PIPE_LAT);
                q.push_back(m);
                if (sc) m_sbusy[dst] = 1'b1;
                else    m_vbusy[dst] = 1'b1;
                m_op = op;
            end
        end
    endtask

    // One clock: check registered outputs, drive inputs, check handshake, advance.
    task automatic step(input bit v, input bit it, input logic [OP_W-1:0] op,
                        input logic [TAG_W-1:0] dst, input bit sc,
                        input bit st, input bit fl, output bit acc);
        bit iter_busy, pipe_busy;
        @(negedge clk);
        check_outputs();
        in_valid = v; in_iter = it; in_op = op; in_dst = dst;
        in_scalar = sc; wb_stall = st; flush = fl;
        #1;
        check("alu_en", alu_en, !st);
        iter_busy = 1'b0;
        pipe_busy = 1'b0;
        foreach (q[i]) begin
            if (q[i].iter) iter_busy = 1'b1;
            else           pipe_busy = 1'b1;
        end
        if (fl || st || iter_busy) check("in_ready_block", in_ready, 0);
        else if (!it)              check("in_ready_pipe", in_ready, 1);
        else if (pipe_busy)        check("in_ready_drain", in_ready, 0);
        else if (since >= 1)       check("in_ready_iter", in_ready, 1);
        acc = v && in_ready;
        @(posedge clk);
        model_edge(acc, it, op, dst, sc, st, fl);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, 0, a);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_in_ready"}, in_ready, 0);
        check({pfx, "_alu_en"}, alu_en, 0);
        check({pfx, "_alu_op"}, alu_op, 0);
        check({pfx, "_alu_start"}, alu_start, 0);
        check({pfx, "_wb_valid"}, wb_valid, 0);
        check({pfx, "_wb_dst"}, wb_dst, 0);
        check({pfx, "_vbusy"}, vbusy, 0);
        check({pfx, "_sbusy"}, sbusy, 0);
    endtask

    initial begin
        bit              acc;
        int              tries;
        bit              pend, p_it, p_sc, st, fl;
        logic [OP_W-1:0] p_op;
        logic [TAG_W-1:0] p_dst;

        rst_n = 1'b0;
        in_valid = 1'b1; in_iter = 1'b0; in_op = '0; in_dst = '0;
        in_scalar = 1'b0; wb_stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();

        // Single pipelined op: result shown after PIPE_LAT edges plus one.
        step(1, 0, 5'h0A, 5'd3, 0, 0, 0, acc);
        check("t1_accept", acc, 1);
        idle(2);
        #2;
        check("t1_wb_valid", wb_valid, 1);
        check("t1_wb_dst", wb_dst, 3);
        check("t1_vbusy3", vbusy[3], 1);
        idle(3);

        // Four back-to-back pipelined ops.
        for (int d = 1; d <= 4; d++) begin
            step(1, 0, OP_W'(d + 8), TAG_W'(d), 0, 0, 0, acc);
            check("t2_accept", acc, 1);
        end
        idle(5);

        // Pipelined op followed by an iterative op that must drain first.
        step(1, 0, 5'h05, 5'd5, 0, 0, 0, acc);
        check("t3_accept_pipe", acc, 1);
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 20) begin
            step(1, 1, 5'h11, 5'd6, 0, 0, 0, acc);
            tries++;
        end
        check("t3_drain_tries", tries, 4);
        idle(ITER_LAT + 2);

        // Stall while the first of two results is on the writeback port.
        step(1, 0, 5'h03, 5'd8, 0, 0, 0, acc);
        step(1, 0, 5'h04, 5'd9, 1, 0, 0, acc);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 5'h07, 5'd10, 0, 1, 0, acc);
            check("t4_stall_noaccept", acc, 0);
        end
        step(1, 0, 5'h07, 5'd10, 0, 0, 0, acc);
        check("t4_accept_after", acc, 1);
        idle(6);

        // Flush during an iterative op with its scalar tag busy.
        step(1, 1, 5'h15, 5'd7, 1, 0, 0, acc);
        check("t5_accept_iter", acc, 1);
        #1;
        check("t5_sbusy7_set", sbusy[7], 1);
        idle(1);
        step(1, 0, 5'h02, 5'd9, 0, 0, 1, acc);
        check("t5_flush_noaccept", acc, 0);
        #1;
        check("t5_sbusy_clear", sbusy, 0);
        check("t5_wb_valid", wb_valid, 0);
        idle(ITER_LAT + 2);

        // Asynchronous reset in the middle of an iterative op.
        step(1, 1, 5'h1C, 5'd12, 0, 0, 0, acc);
        check("t6_accept_iter", acc, 1);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 0, 5'h06, 5'd2, 0, 0, 0, acc);
        check("t6_accept_after", acc, 1);
        idle(4);

        // Random traffic; decode holds an op until it is accepted.
        pend = 1'b0;
        p_it = 1'b0; p_sc = 1'b0; p_op = '0; p_dst = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && $urandom_range(0, 99) < 60) begin
                pend  = 1'b1;
                p_it  = ($urandom_range(0, 99) < 25);
                p_sc  = $urandom_range(0, 1) == 1;
                p_op  = OP_W'($urandom);
                p_dst = TAG_W'($urandom);
            end
            st = ($urandom_range(0, 99) < 15);
            fl = ($urandom_range(0, 99) < 3);
            step(pend, pend && p_it, p_op, p_dst, p_sc, st, fl, acc);
            if (acc) pend = 1'b0;
        end
        idle(ITER_LAT + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
